alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one ALU between NUM_REQ requesters.
- Each cycle it grants at most one requester and issues that requester's operands and command to the ALU as registered operand_a / operand_b / cmd valid-structs.
- It tracks in-flight operations in a requester-ID tag FIFO. Each ALU result is routed back to the requester that issued it, in issue order; the ALU completes operations in order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result data width; must match the package uint width.
- MAX_OUTST, 4, maximum in-flight operations; also the tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester request valid
- req_rdy  out  NUM_REQ  per-requester grant/ready (combinational)
- req_op_a  in  NUM_REQ x DATA_W  operand A per requester
- req_op_b  in  NUM_REQ x DATA_W  operand B per requester
- req_cmd  in  NUM_REQ x alu_cmd_t  command per requester
- alu_op_a_out  out  uint_vld_t  operand A to ALU (vld + data)
- alu_op_b_out  out  uint_vld_t  operand B to ALU
- alu_cmd_out  out  alu_cmd_t  command to ALU
- alu_result_in  in  uint_vld_t  ALU result (vld + data)
- rsp_vld  out  NUM_REQ  one-hot response valid
- rsp_data  out  DATA_W  response data
- err_unexp  out  1  sticky: result arrived with no op in flight

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs clear (vld=0, data=0, cmd=0, rsp_vld=0, err_unexp=0). rr_ptr=0, outst_cnt=0, tag FIFO empty.
- Issue eligibility: issue is allowed iff outst_cnt < MAX_OUTST. There is no same-cycle credit bypass from a returning result.
- Arbitration: among req_vld bits, choose the first set bit at or after rr_ptr (circular).
  - req_rdy[g]=1 only for that winner and only when issue is allowed. req_rdy may depend on req_vld.
  - A requester must hold vld/data stable until it sees rdy.
- Handshake (req_vld[g] & req_rdy[g]):
  - Next cycle: alu_op_a_out={1,op_a[g]}, alu_op_b_out={1,op_b[g]}, alu_cmd_out=cmd[g].
  - With no handshake, the next cycle's vld bits are 0 and data holds its last value.
  - Push g into the tag FIFO. rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
- Issue latency: 1 cycle from handshake to ALU valid.
- Result path:
  - On alu_result_in.vld, pop tag t.
  - Next cycle: rsp_vld = one-hot(t), rsp_data = result data.
  - Response latency: 1 cycle.
- outst_cnt: +1 on issue, -1 on result. Issue and result in the same cycle leave it unchanged.
- Boundary conditions:
  - Full (cnt==MAX_OUTST): req_rdy all 0 until a result returns. Issue resumes the cycle after the decrement.
  - Result with cnt==0: set err_unexp (sticky until reset), rsp_vld stays 0, no FIFO/count change.
  - rr_ptr and FIFO pointers wrap modulo NUM_REQ and MAX_OUTST respectively.
  - rst_n asserted mid-operation: all state clears immediately. In-flight tags are discarded. The ALU is reset on the same rst_n.

Optional Feature:
- Macro: ALU_RR_SCHED_PERF_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ x 16): per-requester saturating count of accepted issues, reset to 0.
  - Adds output stall_cnt (16): saturating count of cycles with any req_vld set but issue blocked by full credits.
- Undefined: neither port nor the counters exist. Functional behaviour is identical.

Decomposition:
- Shared package (existing ALU package): DATA_W constant, uint_vld_t struct, alu_cmd_t enum, and a new req_id_t sized $clog2(NUM_REQ).
- One natural sub-module: alu_tag_fifo, a synchronous FIFO (depth MAX_OUTST, width req_id_t) with push/pop/empty/full.
- Round-robin arbitration and credit logic stay in the top module.

Test Plan:
- Single request: req_vld[2]=1, op_a=5, op_b=3, cmd=ADD.
  - Same cycle: req_rdy[2]=1.
  - Next cycle: alu_op_a_out={1,5}, alu_op_b_out={1,3}.
  - Drive result {1,8}: next cycle rsp_vld=4'b0100, rsp_data=8.
- Fairness: all four req_vld held high from reset for 8 cycles (ALU returning results) -> grant order 0,1,2,3,0,1,2,3.
- Credit stall: MAX_OUTST=4, no results returned.
  - 4 grants, then req_rdy=0 for all requesters.
  - Return one result: the grant resumes the following cycle.
- Out-of-requester-order routing: issue from req 3, 1, 0. Return results 10, 20, 30 -> rsp_vld sequence 1000, 0010, 0001 with data 10, 20, 30.
- Unexpected result: alu_result_in.vld=1 with nothing in flight -> err_unexp=1 next cycle and stays high, rsp_vld=0.
- Reset mid-operation: 2 ops in flight, pulse rst_n low -> outputs 0 asynchronously, err_unexp=0. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_rr_sched_pkg
// Shared ALU types used by the round-robin ALU scheduler and its tag FIFO:
//   ALU_DATA_W  - operand/result width of the shared ALU
//   uint_vld_t  - valid-qualified data word (operands and results)
//   alu_cmd_t   - ALU command encoding
//   req_id_t    - requester identifier for the default requester count
// -----------------------------------------------------------------------------
package alu_rr_sched_pkg;

  localparam int unsigned ALU_DATA_W  = 32;
  localparam int unsigned NUM_REQ_DEF = 4;

  typedef struct packed {
    logic                  vld;
    logic [ALU_DATA_W-1:0] data;
  } uint_vld_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_cmd_t;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/alu_rr_sched_tag_fifo.sv
// -----------------------------------------------------------------------------
// alu_tag_fifo
// Synchronous FIFO holding the requester ID of every in-flight ALU operation,
// in issue order. Head entry is presented combinationally on dout_o.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push_i, din_i   - write an ID (ignored when full)
//   pop_i           - drop the head entry (ignored when empty)
//   dout_o          - head entry
//   empty_o, full_o - occupancy flags
// DEPTH must be a power of two (>= 2).
// -----------------------------------------------------------------------------
module alu_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]             wr_ptr_q;
  logic [AW:0]             rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointer update; pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
// Round-robin scheduler sharing one in-order ALU between NUM_REQ requesters.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_vld/req_rdy   - per-requester request handshake (req_rdy combinational)
//   req_op_a/b, req_cmd - per-requester operands and command
//   alu_op_a_out/b_out, alu_cmd_out - registered issue to the ALU
//   alu_result_in     - ALU result, returned in issue order
//   rsp_vld, rsp_data - registered one-hot response to the issuing requester
//   err_unexp         - sticky flag: result arrived with nothing in flight
// Optional (macro ALU_RR_SCHED_PERF_EN):
//   grant_cnt         - per-requester saturating accepted-issue counters
//   stall_cnt         - saturating count of cycles blocked by full credits
// -----------------------------------------------------------------------------
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_op_b,
  input  alu_cmd_t [NUM_REQ-1:0]         req_cmd,
  output uint_vld_t                      alu_op_a_out,
  output uint_vld_t                      alu_op_b_out,
  output alu_cmd_t                       alu_cmd_out,
  input  uint_vld_t                      alu_result_in,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [DATA_W-1:0]              rsp_data,
`ifdef ALU_RR_SCHED_PERF_EN
  output logic [NUM_REQ-1:0][15:0]       grant_cnt,
  output logic [15:0]                    stall_cnt,
`endif
  output logic                           err_unexp
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   outst_cnt_q, outst_cnt_d;
  uint_vld_t          op_a_q, op_a_d;
  uint_vld_t          op_b_q, op_b_d;
  alu_cmd_t           cmd_q, cmd_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  logic [ID_W-1:0]    win_s;
  logic               found_s;
  logic               issue_ok_s;
  logic               issue_s;
  logic               pop_s;
  logic [ID_W-1:0]    tag_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;

  // Circular priority search: first valid requester at or after rr_ptr.
  always_comb begin
    int          sum;
    logic [ID_W-1:0] cand;
    found_s = 1'b0;
    win_s   = '0;
    sum     = 0;
    cand    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sum  = (int'(rr_ptr_q) + i) % int'(NUM_REQ);
      cand = ID_W'(sum);
      if (!found_s && req_vld[cand]) begin
        found_s = 1'b1;
        win_s   = cand;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Credits are judged on the registered count only: a result returning this
  // cycle frees its slot for the next cycle, not this one.
  assign issue_ok_s = (outst_cnt_q < CNT_W'(MAX_OUTST));
  assign issue_s    = found_s & issue_ok_s;
  assign req_rdy    = issue_s ? (ONE_REQ << win_s) : '0;
  assign pop_s      = alu_result_in.vld & (outst_cnt_q != '0);

  alu_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue_s),
    .din_i   (win_s),
    .pop_i   (pop_s),
    .dout_o  (tag_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  // Next-state for issue, credit, response and error state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    outst_cnt_d = outst_cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cmd_d       = cmd_q;
    rsp_vld_d   = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    if (issue_s) begin
      op_a_d.vld  = 1'b1;
      op_a_d.data = req_op_a[win_s];
      op_b_d.vld  = 1'b1;
      op_b_d.data = req_op_b[win_s];
      cmd_d       = req_cmd[win_s];
      rr_ptr_d    = (win_s == ID_W'(NUM_REQ - 1)) ? '0 : (win_s + ID_W'(1));
    end else begin
      op_a_d.vld  = 1'b0;
      op_b_d.vld  = 1'b0;
    end

    case ({issue_s, pop_s})
      2'b10:   outst_cnt_d = outst_cnt_q + CNT_W'(1);
      2'b01:   outst_cnt_d = outst_cnt_q - CNT_W'(1);
      default: outst_cnt_d = outst_cnt_q;
    endcase

    if (pop_s) begin
      rsp_vld_d  = ONE_REQ << tag_s;
      rsp_data_d = alu_result_in.data;
    end else begin
      rsp_vld_d  = '0;
    end

    if (alu_result_in.vld && (outst_cnt_q == '0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      outst_cnt_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cmd_q       <= ALU_ADD;
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      outst_cnt_q <= outst_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cmd_q       <= cmd_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign alu_op_a_out = op_a_q;
  assign alu_op_b_out = op_b_q;
  assign alu_cmd_out  = cmd_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_data     = rsp_data_q;
  assign err_unexp    = err_q;

`ifdef ALU_RR_SCHED_PERF_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;
  logic [15:0]              stall_cnt_q;
  logic                     stall_s;

  assign stall_s = (|req_vld) & ~issue_ok_s;

  // Saturating per-requester grant counters and full-credit stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        if (issue_s && (win_s == ID_W'(r)) && (grant_cnt_q[r] != 16'hFFFF)) begin
          grant_cnt_q[r] <= grant_cnt_q[r] + 16'd1;
        end
      end
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
// Self-checking bench for alu_rr_sched. A behavioural model (in-flight queue of
// requester IDs, round-robin pointer, expected registered outputs) predicts
// every output; directed scenarios add fixed expectations on top.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_rr_sched;
  import alu_rr_sched_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NR-1:0]          req_vld;
  logic [NR-1:0]          req_rdy;
  logic [NR-1:0][DW-1:0]  req_op_a;
  logic [NR-1:0][DW-1:0]  req_op_b;
  alu_cmd_t [NR-1:0]      req_cmd;
  uint_vld_t              alu_op_a_out;
  uint_vld_t              alu_op_b_out;
  alu_cmd_t               alu_cmd_out;
  uint_vld_t              alu_result_in;
  logic [NR-1:0]          rsp_vld;
  logic [DW-1:0]          rsp_data;
  logic                   err_unexp;
`ifdef ALU_RR_SCHED_PERF_EN
  logic [NR-1:0][15:0]    grant_cnt;
  logic [15:0]            stall_cnt;
`endif

  alu_rr_sched #(.NUM_REQ(NR), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .req_cmd       (req_cmd),
    .alu_op_a_out  (alu_op_a_out),
    .alu_op_b_out  (alu_op_b_out),
    .alu_cmd_out   (alu_cmd_out),
    .alu_result_in (alu_result_in),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
`ifdef ALU_RR_SCHED_PERF_EN
    .grant_cnt     (grant_cnt),
    .stall_cnt     (stall_cnt),
`endif
    .err_unexp     (err_unexp)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int            m_q[$];
  int            m_ptr;
  bit            m_err;
  bit            m_op_vld;
  logic [31:0]   m_a_data;
  logic [31:0]   m_b_data;
  logic [2:0]    m_cmd;
  logic [NR-1:0] m_rsp_vld;
  logic [31:0]   m_rsp_data;
  int            last_grant;
  logic [NR-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr      = 0;
    m_err      = 1'b0;
    m_op_vld   = 1'b0;
    m_a_data   = '0;
    m_b_data   = '0;
    m_cmd      = '0;
    m_rsp_vld  = '0;
    m_rsp_data = '0;
  endtask

  task automatic check_outputs();
    chk("alu_op_a", alu_op_a_out, {m_op_vld, m_a_data});
    chk("alu_op_b", alu_op_b_out, {m_op_vld, m_b_data});
    chk("alu_cmd",  alu_cmd_out,  m_cmd);
    chk("rsp_vld",  rsp_vld,      m_rsp_vld);
    chk("rsp_data", rsp_data,     m_rsp_data);
    chk("err_unexp", err_unexp,   m_err);
  endtask

  task automatic idle_inputs();
    req_vld           = '0;
    alu_result_in.vld = 1'b0;
    alu_result_in.data = '0;
  endtask

  task automatic new_req(input int r);
    req_op_a[r] = $urandom;
    req_op_b[r] = $urandom;
    req_cmd[r]  = alu_cmd_t'($urandom_range(0, 4));
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic step();
    int            win;
    int            t;
    logic [NR-1:0] exp_rdy;
    #1;
    win = -1;
    if (m_q.size() < MO) begin
      for (int i = 0; i < NR; i++) begin
        if (win < 0 && req_vld[(m_ptr + i) % NR]) win = (m_ptr + i) % NR;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_rdy", req_rdy, exp_rdy);
    last_rdy   = req_rdy;
    last_grant = win;
    // Result side uses the in-flight set as it stood before this cycle's issue.
    m_rsp_vld = '0;
    if (alu_result_in.vld) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        t = m_q.pop_front();
        m_rsp_vld[t] = 1'b1;
        m_rsp_data   = alu_result_in.data;
      end
    end
    if (win >= 0) begin
      m_q.push_back(win);
      m_ptr    = (win + 1) % NR;
      m_op_vld = 1'b1;
      m_a_data = req_op_a[win];
      m_b_data = req_op_b[win];
      m_cmd    = req_cmd[win];
    end else begin
      m_op_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting at a negedge; released on the next one.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_vld = '0;
    while (m_q.size() > 0) begin
      alu_result_in.vld  = 1'b1;
      alu_result_in.data = $urandom;
      step();
    end
    alu_result_in.vld = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] one;
    logic [NR-1:0] route_vld [3];
    logic [31:0]   route_dat [3];
    one = 4'b0001;
    rst_n = 1'b0;
    req_op_a = '0;
    req_op_b = '0;
    for (int r = 0; r < NR; r++) req_cmd[r] = ALU_ADD;
    idle_inputs();
    model_reset();
    pulse_reset();

    // Single request from requester 2
    req_vld     = 4'b0100;
    req_op_a[2] = 32'd5;
    req_op_b[2] = 32'd3;
    req_cmd[2]  = ALU_ADD;
    step();
    chk("single_rdy", last_rdy, 4'b0100);
    chk("single_a", alu_op_a_out, {1'b1, 32'd5});
    chk("single_b", alu_op_b_out, {1'b1, 32'd3});
    req_vld = '0;
    alu_result_in.vld  = 1'b1;
    alu_result_in.data = 32'd8;
    step();
    alu_result_in.vld = 1'b0;
    chk("single_rsp_vld", rsp_vld, 4'b0100);
    chk("single_rsp_data", rsp_data, 32'd8);

    // Fairness with all requesters held valid from reset
    pulse_reset();
    for (int r = 0; r < NR; r++) new_req(r);
    req_vld = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      alu_result_in.vld  = (m_q.size() > 0);
      alu_result_in.data = 32'(i);
      step();
      chk("fair_grant", last_rdy, one << (i % NR));
    end
    drain();

    // Credit stall: no results returned
    pulse_reset();
    req_vld = 4'b1111;
    for (int i = 0; i < MO; i++) begin
      step();
      chk("stall_grant", last_rdy, one << i);
    end
    step();
    chk("stall_full", last_rdy, 4'b0000);
    alu_result_in.vld  = 1'b1;
    alu_result_in.data = 32'h55;
    step();
    chk("stall_no_bypass", last_rdy, 4'b0000);
    alu_result_in.vld = 1'b0;
    step();
    chk("stall_resume", last_rdy, 4'b0001);
    drain();

    // Out-of-requester-order routing
    pulse_reset();
    req_vld = 4'b1000; step();
    req_vld = 4'b0010; step();
    req_vld = 4'b0001; step();
    req_vld = '0;
    route_vld[0] = 4'b1000; route_dat[0] = 32'd10;
    route_vld[1] = 4'b0010; route_dat[1] = 32'd20;
    route_vld[2] = 4'b0001; route_dat[2] = 32'd30;
    for (int i = 0; i < 3; i++) begin
      alu_result_in.vld  = 1'b1;
      alu_result_in.data = route_dat[i];
      step();
      chk("route_vld", rsp_vld, route_vld[i]);
      chk("route_data", rsp_data, route_dat[i]);
    end
    alu_result_in.vld = 1'b0;

    // Unexpected result with nothing in flight
    alu_result_in.vld  = 1'b1;
    alu_result_in.data = 32'd99;
    step();
    alu_result_in.vld = 1'b0;
    chk("unexp_err", err_unexp, 1'b1);
    chk("unexp_rsp", rsp_vld, 4'b0000);
    step();
    chk("unexp_sticky", err_unexp, 1'b1);

    // Reset with two operations in flight
    req_vld = 4'b1111;
    step();
    step();
    pulse_reset();
    chk("rst_err", err_unexp, 1'b0);
    chk("rst_op_vld", alu_op_a_out.vld, 1'b0);
    step();
    chk("rst_first_grant", last_rdy, 4'b0001);
    drain();

    // Randomized traffic against the model
    pulse_reset();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      alu_result_in.vld  = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      alu_result_in.data = $urandom;
      step();
      for (int r = 0; r < NR; r++) begin
        if (last_grant == r) begin
          req_vld[r] = 1'($urandom_range(0, 1));
          new_req(r);
        end else if (!req_vld[r] && $urandom_range(0, 2) == 0) begin
          req_vld[r] = 1'b1;
          new_req(r);
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
